// File: rtl/demux1to4_stream.sv
// Registered 1-to-4 stream demultiplexer with a one-word holding register per output channel.
// Optional DEMUX_ROUND_ROBIN_EN: destination comes from an internal rotating pointer instead of S.
module demux1to4_stream #(
  parameter int N = 32
) (
  input  logic           clk,
  input  logic           rstb,
  input  logic [N-1:0]   X,
  input  logic           X_valid,
  output logic           X_ready,
  input  logic [1:0]     S,
  output logic [4*N-1:0] Z,
  output logic [3:0]     Z_valid,
  input  logic [3:0]     Z_ready,
  output logic [15:0]    accept_count
);

  localparam logic [0:0] ST_EMPTY = 1'b0;
  localparam logic [0:0] ST_FULL  = 1'b1;

  logic [1:0]  w_dest;
  logic        w_accept;
  logic [3:0]  w_load;
  logic [15:0] r_count;

`ifdef DEMUX_ROUND_ROBIN_EN
  logic [1:0] r_ptr;
  logic       w_unused_s;

  // The pointer only moves on an accept; a stalled channel blocks the stream rather than being skipped.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      r_ptr <= 2'd0;
    end else if (w_accept) begin
      r_ptr <= r_ptr + 2'd1;
    end
  end

  assign w_dest     = r_ptr;
  assign w_unused_s = ^S;
`else
  assign w_dest = S;
`endif

  // A full channel can still take a word when its consumer drains on the same edge.
  assign X_ready  = !Z_valid[w_dest] || Z_ready[w_dest];
  assign w_accept = X_valid && X_ready;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_ch
      logic [0:0]   r_state;
      logic [0:0]   w_state_next;
      logic [N-1:0] r_data;

      assign w_load[gi] = w_accept && (w_dest == 2'(gi));

      always_comb begin
        w_state_next = r_state;
        case (r_state)
          ST_EMPTY: if (w_load[gi]) w_state_next = ST_FULL;
          ST_FULL:  if (!w_load[gi] && Z_ready[gi]) w_state_next = ST_EMPTY;
          default:  w_state_next = ST_EMPTY;
        endcase
      end

      always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
          r_state <= ST_EMPTY;
        end else begin
          r_state <= w_state_next;
        end
      end

      // Data is not cleared on drain; it is only meaningful while the channel is full.
      always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
          r_data <= '0;
        end else if (w_load[gi]) begin
          r_data <= X;
        end
      end

      assign Z[gi*N +: N] = r_data;
      assign Z_valid[gi]  = (r_state == ST_FULL);
    end
  endgenerate

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      r_count <= 16'd0;
    end else if (w_accept) begin
      r_count <= r_count + 16'd1;
    end
  end

  assign accept_count = r_count;

endmodule

// File: tb/tb_demux1to4_stream.sv
// Self-checking bench for demux1to4_stream: directed scenarios plus randomized traffic
// checked against a per-channel one-slot buffer model.
module tb_demux1to4_stream;
  localparam int N = 32;

  logic           clk = 1'b0;
  logic           rstb;
  logic [N-1:0]   X;
  logic           X_valid;
  logic           X_ready;
  logic [1:0]     S;
  logic [4*N-1:0] Z;
  logic [3:0]     Z_valid;
  logic [3:0]     Z_ready;
  logic [15:0]    accept_count;

  int n_checks = 0;
  int n_fail   = 0;

  // Behavioural model: each channel is a buffer holding at most one word.
  logic         m_full [4];
  logic [N-1:0] m_word [4];
  int unsigned  m_count;

  demux1to4_stream #(.N(N)) dut (
    .clk(clk), .rstb(rstb), .X(X), .X_valid(X_valid), .X_ready(X_ready), .S(S),
    .Z(Z), .Z_valid(Z_valid), .Z_ready(Z_ready), .accept_count(accept_count)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  // Source must hold X and S stable while stalled.
  logic         prev_stall = 1'b0;
  logic [N-1:0] prev_x;
  logic [1:0]   prev_s;
  always @(negedge clk) begin
    if (rstb && prev_stall)
      assert (X == prev_x && S == prev_s) else $error("source changed X/S while stalled");
    prev_stall <= rstb && X_valid && !X_ready;
    prev_x     <= X;
    prev_s     <= S;
  end

  function automatic int model_dest();
`ifdef DEMUX_ROUND_ROBIN_EN
    return int'(m_count % 4);
`else
    return int'(S);
`endif
  endfunction

  function automatic logic model_ready();
    int d;
    d = model_dest();
    return !m_full[d] || Z_ready[d];
  endfunction

  function automatic logic [3:0] model_valid();
    return {m_full[3], m_full[2], m_full[1], m_full[0]};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 4; i++) m_full[i] = 1'b0;
    m_count = 0;
  endtask

  // Advance one clock edge and update the model; returns at edge + 1.
  task automatic tick();
    logic acc;
    int   d;
    d   = model_dest();
    acc = X_valid && model_ready();
    @(posedge clk);
    for (int i = 0; i < 4; i++)
      if (m_full[i] && Z_ready[i]) m_full[i] = 1'b0;
    if (acc) begin
      m_full[d] = 1'b1;
      m_word[d] = X;
      m_count   = (m_count + 1) % 65536;
      $display("[%0t] accept ch%0d data=%h count=%0d", $time, d, X, m_count);
    end
    #1;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rstb = 1'b0;
    model_reset();
    @(negedge clk);
    rstb = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rstb = 1'b0; X = '0; S = 2'd0; X_valid = 1'b0; Z_ready = 4'hF;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if (Z_valid !== 4'b0000) begin n_fail++; $display("FAIL reset_valid: got %b expected 0000", Z_valid); end
    n_checks++;
    if (accept_count !== 16'd0) begin n_fail++; $display("FAIL reset_count: got %0d expected 0", accept_count); end
    n_checks++;
    if (Z !== '0) begin n_fail++; $display("FAIL reset_data: got %h expected 0", Z); end
    @(negedge clk);
    rstb = 1'b1;
    @(posedge clk);
    #1;
    n_checks++;
    if (X_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b expected 1", X_ready); end
  endtask

`ifndef DEMUX_ROUND_ROBIN_EN
  task automatic test_single_route();
    X = 32'hDEADBEEF; S = 2'd2; X_valid = 1'b1; Z_ready = 4'b0000;
    tick();
    X_valid = 1'b0;
    n_checks++;
    if (Z_valid !== 4'b0100) begin n_fail++; $display("FAIL single_valid: got %b expected 0100", Z_valid); end
    n_checks++;
    if (Z[95:64] !== 32'hDEADBEEF) begin n_fail++; $display("FAIL single_data: got %h expected deadbeef", Z[95:64]); end
    n_checks++;
    if (accept_count !== 16'd1) begin n_fail++; $display("FAIL single_count: got %0d expected 1", accept_count); end
  endtask

  task automatic test_backpressure();
    X = 32'h0000A5A5; S = 2'd1; X_valid = 1'b1; Z_ready = 4'b0000;
    tick();
    X = 32'h00000011;
    for (int c = 0; c < 5; c++) begin
      #1;
      n_checks++;
      if (X_ready !== 1'b0) begin n_fail++; $display("FAIL bp_ready cyc%0d: got %b expected 0", c, X_ready); end
      tick();
      n_checks++;
      if (Z[63:32] !== 32'h0000A5A5 || accept_count !== 16'd2)
        begin n_fail++; $display("FAIL bp_hold cyc%0d: got data=%h count=%0d expected a5a5/2", c, Z[63:32], accept_count); end
    end
    Z_ready = 4'b0010;
    #1;
    n_checks++;
    if (X_ready !== 1'b1) begin n_fail++; $display("FAIL bp_release_ready: got %b expected 1", X_ready); end
    tick();
    X_valid = 1'b0; Z_ready = 4'b0000;
    n_checks++;
    if (Z[63:32] !== 32'h00000011 || Z_valid[1] !== 1'b1 || accept_count !== 16'd3)
      begin n_fail++; $display("FAIL bp_replace: got data=%h valid=%b count=%0d expected 11/1/3", Z[63:32], Z_valid[1], accept_count); end
  endtask
`endif

  task automatic test_interleave();
    int d;
    apply_reset();
    Z_ready = 4'hF;
    for (int k = 0; k < 8; k++) begin
      X = N'(k); S = 2'(k % 4); X_valid = 1'b1;
      #1;
      n_checks++;
      if (X_ready !== 1'b1) begin n_fail++; $display("FAIL il_ready word%0d: got %b expected 1", k, X_ready); end
      tick();
      d = k % 4;
      n_checks++;
      if (Z[d*N +: N] !== N'(k) || Z_valid[d] !== 1'b1)
        begin n_fail++; $display("FAIL il_data ch%0d: got %h valid=%b expected %h valid=1", d, Z[d*N +: N], Z_valid[d], k); end
    end
    X_valid = 1'b0;
    n_checks++;
    if (accept_count !== 16'd8) begin n_fail++; $display("FAIL il_count: got %0d expected 8", accept_count); end
  endtask

  task automatic test_random();
    logic stalled;
    apply_reset();
    stalled = 1'b0;
    for (int c = 0; c < 250; c++) begin
      if (!stalled) begin
        X       = $urandom;
        S       = 2'($urandom_range(0, 3));
        X_valid = ($urandom_range(0, 3) != 0);
      end
      Z_ready = 4'($urandom);
      #1;
      n_checks++;
      if (X_ready !== model_ready()) begin n_fail++; $display("FAIL rnd_ready cyc%0d: got %b expected %b", c, X_ready, model_ready()); end
      stalled = X_valid && !model_ready();
      tick();
      n_checks++;
      if (Z_valid !== model_valid()) begin n_fail++; $display("FAIL rnd_valid cyc%0d: got %b expected %b", c, Z_valid, model_valid()); end
      for (int i = 0; i < 4; i++) begin
        if (m_full[i]) begin
          n_checks++;
          if (Z[i*N +: N] !== m_word[i]) begin n_fail++; $display("FAIL rnd_data cyc%0d ch%0d: got %h expected %h", c, i, Z[i*N +: N], m_word[i]); end
        end
      end
      n_checks++;
      if (accept_count !== 16'(m_count)) begin n_fail++; $display("FAIL rnd_count cyc%0d: got %0d expected %0d", c, accept_count, m_count); end
    end
    X_valid = 1'b0;
  endtask

  task automatic test_reset_mid();
    apply_reset();
    Z_ready = 4'b0000;
    for (int k = 0; k < 4; k++) begin
      X = 32'hC0DE0000 + N'(k); S = 2'(k); X_valid = 1'b1;
      tick();
    end
    X_valid = 1'b0;
    n_checks++;
    if (Z_valid !== 4'b1111) begin n_fail++; $display("FAIL mid_fill: got %b expected 1111", Z_valid); end
    #2;
    rstb = 1'b0;
    model_reset();
    #1;
    n_checks++;
    if (Z_valid !== 4'b0000) begin n_fail++; $display("FAIL mid_reset_valid: got %b expected 0000", Z_valid); end
    n_checks++;
    if (accept_count !== 16'd0 || Z !== '0) begin n_fail++; $display("FAIL mid_reset_state: got count=%0d Z=%h expected 0/0", accept_count, Z); end
    @(negedge clk);
    rstb = 1'b1;
    @(posedge clk);
    #1;
  endtask

`ifdef DEMUX_ROUND_ROBIN_EN
  task automatic test_round_robin();
    apply_reset();
    S = 2'd3; Z_ready = 4'b1011;
    for (int k = 0; k < 6; k++) begin
      X = 32'h0000BB00 + N'(k); X_valid = 1'b1;
      #1;
      n_checks++;
      if (X_ready !== 1'b1) begin n_fail++; $display("FAIL rr_ready word%0d: got %b expected 1", k, X_ready); end
      tick();
      n_checks++;
      if (Z[(k%4)*N +: N] !== 32'h0000BB00 + N'(k) || Z_valid[k%4] !== 1'b1)
        begin n_fail++; $display("FAIL rr_dest word%0d: got %h on ch%0d expected %h", k, Z[(k%4)*N +: N], k % 4, 32'h0000BB00 + k); end
    end
    X = 32'h0000BB06;
    for (int c = 0; c < 3; c++) begin
      #1;
      n_checks++;
      if (X_ready !== 1'b0) begin n_fail++; $display("FAIL rr_stall cyc%0d: got %b expected 0", c, X_ready); end
      tick();
    end
    n_checks++;
    if (accept_count !== 16'd6) begin n_fail++; $display("FAIL rr_stall_count: got %0d expected 6", accept_count); end
    Z_ready = 4'hF;
    tick();
    X_valid = 1'b0;
    n_checks++;
    if (Z[2*N +: N] !== 32'h0000BB06 || Z_valid[2] !== 1'b1)
      begin n_fail++; $display("FAIL rr_resume: got %h valid=%b on ch2 expected 0000bb06 valid=1", Z[2*N +: N], Z_valid[2]); end
  endtask
`endif

  initial begin
    test_reset();
`ifndef DEMUX_ROUND_ROBIN_EN
    test_single_route();
    test_backpressure();
`else
    test_round_robin();
`endif
    test_interleave();
    test_random();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/demux1to4_stream.md
Name: demux1to4_stream

Overview:
- Registered 1-to-4 stream demultiplexer: the distribution end of the shared 4-way datapath select.
- Takes one N-bit input stream with a 2-bit destination select and delivers each word to exactly one of four output channels.
- Each output channel has a one-word holding register and a valid/ready handshake.
- Sits between a single producer (ALU/bus result) and four independent consumers.

Parameters:
N, 32, data width of input and of each output channel

Ports:
clk  input  1  system clock, all state updates on rising edge
rstb  input  1  asynchronous active-low reset
X  input  N  input data word
X_valid  input  1  X and S are valid this cycle
X_ready  output  1  block can accept the word this cycle
S  input  2  destination channel index (0..3)
Z  output  4*N  packed output data; channel i on bits [i*N +: N]
Z_valid  output  4  per-channel holding register full
Z_ready  input  4  per-channel consumer ready
accept_count  output  16  total words accepted since reset

Behaviour:
- Reset (rstb low, asynchronous, any cycle): Z_valid=4'b0000, Z=0, accept_count=0, round-robin pointer=0. Takes effect immediately. Any in-flight word is discarded. First accept is possible on the first rising edge after rstb rises.
- Destination d: d = S, or the round-robin pointer when ROUND_ROBIN_EN is defined.
- X_ready = !Z_valid[d] || Z_ready[d]. This is combinational from S, Z_valid and Z_ready. When X_valid is low, X_ready still reflects the current S.
- Accept = X_valid && X_ready. On accept:
  - Z[d] <= X.
  - Z_valid[d] <= 1.
  - accept_count <= accept_count + 1, wrapping 16'hFFFF -> 0.
- Latency: the word is visible on Z[d] with Z_valid[d]=1 on the cycle after the accept edge.
- Drain: Z_valid[i] && Z_ready[i] with no load to channel i on the same edge -> Z_valid[i] <= 0. Z[i] holds its last value; it is don't-care when not valid but is not cleared.
- Simultaneous drain and load on the same channel: the new word replaces the old one and Z_valid stays 1. This gives full throughput, one word per cycle per channel.
- Channels other than d are unaffected by the accept: their data and valid hold unless they drain themselves.
- Multiple channels may drain on the same edge; at most one channel loads per edge.
- Stall: X_valid && !X_ready -> no state change from the input side. The source must hold X and S stable until accepted; the bench asserts this.
- Ordering: per channel, words are delivered in accept order. No word is ever dropped or duplicated.
- X_valid low: no accept, no count increment; the select is ignored.
- State per channel is a two-state FSM:
  - EMPTY -> FULL on load.
  - FULL -> EMPTY on drain without load.
  - FULL -> FULL on load (with drain), or when neither drain nor load occurs.

Optional Feature:
- Macro: DEMUX_ROUND_ROBIN_EN.
- Defined:
  - S is ignored.
  - An internal 2-bit pointer selects d. It resets to 0 and increments by 1 (3 -> 0 wrap) on every accept only.
  - If the pointed channel is full and not ready, X_ready=0 and the pointer does not advance; there is no skipping to a free channel.
- Not defined: routing is by S only and no pointer logic is synthesized.

Test Plan:
- Reset then idle: rstb low 3 cycles, all Z_ready=1 -> Z_valid=0000, accept_count=0, X_ready=1 after release.
- Single route: X=32'hDEADBEEF, S=2, X_valid one cycle, Z_ready=0000 -> next cycle Z_valid=0100, Z[95:64]=DEADBEEF, accept_count=1. Other channels stay invalid.
- Backpressure: channel 1 full with Z_ready[1]=0, present X=32'h11, S=1 -> X_ready=0 and no change for 5 cycles. Raise Z_ready[1] -> accept on that edge; the old word drains and Z[63:32]=0x11 the next cycle with Z_valid[1] still 1.
- Interleave and throughput: stream 8 words 0..7 with S=0,1,2,3,0,1,2,3, all Z_ready=1 -> one accept per cycle and X_ready constant 1. Channel 0 outputs 0 then 4, channel 3 outputs 3 then 7; accept_count=8.
- Reset mid-operation: Z_valid=1111, assert rstb mid-cycle (between edges) -> Z_valid=0000 immediately, before the next edge; accept_count=0.
- With DEMUX_ROUND_ROBIN_EN: S held at 3, 6 words accepted -> destinations 0,1,2,3,0,1. Then stall channel 2 (full, Z_ready[2]=0) -> X_ready=0 and the pointer stays at 2.
